fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the RV32I core. Sits directly upstream of the combinational byte-addressed instruction ROM.
- Owns the program counter and drives the ROM address. Captures the returned word plus its PC into an IF/ID pipeline register for the decoder.
- Handles sequential increment, branch/jump redirect with flush, decode-side stall, and end-of-memory halt.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- IMEM_BYTES, 128: ROM size in bytes. Fetch addresses must satisfy addr+3 < IMEM_BYTES.
- NOP_INSTR, 32'h0000_0013: bubble word (addi x0,x0,0) inserted on flush/halt.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hold PC and IF/ID contents.
- redirect  input  1  taken branch/jump this cycle.
- redirect_pc  input  32  target byte address for redirect.
- imem_addr  output  32  ROM byte address; combinational copy of pc.
- imem_instr  input  32  ROM read data, combinational from imem_addr.
- pc  output  32  current fetch PC register.
- if_id_pc  output  32  PC of the instruction held in IF/ID.
- if_id_instr  output  32  instruction held in IF/ID.
- if_id_valid  output  1  IF/ID holds a real fetched instruction.
- fetch_done  output  1  sticky; PC ran past end of ROM.
- misalign_err  output  1  sticky; a redirect target had [1:0] != 0.

Behaviour:
- Reset (async, any time, including mid-stall or mid-redirect):
  - pc=RESET_PC, if_id_pc=0, if_id_instr=NOP_INSTR.
  - if_id_valid=0, fetch_done=0, misalign_err=0.
- imem_addr = pc at all times, no register. ROM word is sampled at the next rising edge, so latency PC→if_id_instr is 1 cycle.
- Per-edge priority, highest first: reset > redirect > fetch_done > stall > normal.
- Normal:
  - if_id_instr<=imem_instr, if_id_pc<=pc, if_id_valid<=1.
  - pc<=pc+4, 32-bit unsigned, no wrap logic needed below IMEM_BYTES.
- Redirect (wins over stall):
  - Flush IF/ID: if_id_instr<=NOP_INSTR, if_id_valid<=0, if_id_pc<=pc.
  - pc<={redirect_pc[31:2],2'b00}.
  - If redirect_pc[1:0]!=0, set misalign_err.
  - If aligned target+3 >= IMEM_BYTES, set fetch_done and leave pc unchanged.
- Stall without redirect: pc and all IF/ID fields hold.
- End of memory:
  - In the normal case, if pc+4+3 >= IMEM_BYTES, set fetch_done and leave pc unchanged.
  - The instruction at the final word is still captured valid on that edge.
- fetch_done=1:
  - pc frozen.
  - Every edge loads a NOP bubble with if_id_valid=0. Stall is ignored.
  - A later redirect to an in-range target clears fetch_done and resumes fetching.
- misalign_err clears only on reset.
- No outputs are combinational from stall/redirect. Only imem_addr is combinational, and only from pc.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds two outputs:
  - perf_fetched[31:0]: increments on every edge that loads if_id_valid=1.
  - perf_bubbles[31:0]: increments on every edge that loads a bubble (redirect or fetch_done), and on every stalled edge.
  - Both counters reset to 0 and wrap at 2^32.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset then 3 free-running edges with the standard program:
  - if_id sequence (pc,instr) = (0,ff600293), (4,00528333), (8,406283b3).
  - pc=12 after the third edge.
- Stall held 2 cycles at pc=8 → pc stays 8, IF/ID stays (4,00528333,valid). On release, the next edge loads (8,406283b3).
- Redirect with redirect_pc=0x2C and stall=1 on the same edge → pc=0x2C, if_id_valid=0, if_id_instr=00000013. The next edge loads (2C,000003b3).
- Run to pc=0x7C (IMEM_BYTES=128) → that edge captures ROM word 0x7C valid and sets fetch_done, pc stays 0x7C. Subsequent edges give valid=0 NOPs. Then redirect to 0x0 → fetch_done=0 and the next edge loads (0,ff600293).
- Redirect to 0x0000_0006 → pc=4, misalign_err=1 and stays 1 through 10 more cycles. Reset clears it.
- Assert reset asynchronously mid-cycle while pc=0x20 and stall=1 → pc=0 and if_id_valid=0 before the next clock edge. With FETCH_PERF_CNT_EN defined, both counters read 0.

Source files
------------

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I instruction fetch: PC, ROM address, IF/ID register
// Optional FETCH_PERF_CNT_EN adds perf_fetched/perf_bubbles counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 128,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] pc,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        fetch_done,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles,
`endif
    output logic        misalign_err
);

    localparam logic [32:0] LIMIT = 33'(IMEM_BYTES);

    logic [31:0] target;
    logic [32:0] target_end;
    logic [32:0] next_end;
    logic        target_oob;
    logic        seq_last;

    // End checks are done in 33 bits so targets near 2^32 cannot wrap into range.
    assign target     = {redirect_pc[31:2], 2'b00};
    assign target_end = {1'b0, target} + 33'd3;
    assign next_end   = {1'b0, pc} + 33'd7;
    assign target_oob = (target_end >= LIMIT);
    assign seq_last   = (next_end >= LIMIT);

    assign imem_addr  = pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc           <= RESET_PC;
            if_id_pc     <= 32'h0000_0000;
            if_id_instr  <= NOP_INSTR;
            if_id_valid  <= 1'b0;
            fetch_done   <= 1'b0;
            misalign_err <= 1'b0;
`ifdef FETCH_PERF_CNT_EN
            perf_fetched <= 32'h0000_0000;
            perf_bubbles <= 32'h0000_0000;
`endif
        end else if (redirect) begin
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
            if_id_pc    <= pc;
            if (redirect_pc[1:0] != 2'b00) begin
                misalign_err <= 1'b1;
            end
            if (target_oob) begin
                fetch_done <= 1'b1;
            end else begin
                pc         <= target;
                fetch_done <= 1'b0;
            end
`ifdef FETCH_PERF_CNT_EN
            perf_bubbles <= perf_bubbles + 32'd1;
`endif
        end else if (fetch_done) begin
            // Halted: keep feeding bubbles until a redirect restarts fetch.
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
            if_id_pc    <= pc;
`ifdef FETCH_PERF_CNT_EN
            perf_bubbles <= perf_bubbles + 32'd1;
`endif
        end else if (stall) begin
`ifdef FETCH_PERF_CNT_EN
            perf_bubbles <= perf_bubbles + 32'd1;
`endif
        end else begin
            if_id_instr <= imem_instr;
            if_id_pc    <= pc;
            if_id_valid <= 1'b1;
            if (seq_last) begin
                fetch_done <= 1'b1;
            end else begin
                pc <= pc + 32'd4;
            end
`ifdef FETCH_PERF_CNT_EN
            perf_fetched <= perf_fetched + 32'd1;
`endif
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed test of fetch_stage against a behavioural model
module tb_fetch_stage;

    localparam int IMEM = 128;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] pc;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        fetch_done;
    logic        misalign_err;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;
`endif

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .IMEM_BYTES(IMEM),
        .NOP_INSTR (NOP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_instr  (imem_instr),
        .pc          (pc),
        .if_id_pc    (if_id_pc),
        .if_id_instr (if_id_instr),
        .if_id_valid (if_id_valid),
        .fetch_done  (fetch_done),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched(perf_fetched),
        .perf_bubbles(perf_bubbles),
`endif
        .misalign_err(misalign_err)
    );

    logic [31:0] rom [0:31];
    int n_checks = 0;
    int n_fail   = 0;

    assign imem_instr = (imem_addr < 32'(IMEM)) ? rom[imem_addr[6:2]] : 32'h0000_0000;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: architectural state updated from the fetch rules.
    longint      m_pc;
    logic [31:0] m_instr, m_ifpc;
    logic        m_valid, m_done, m_mis, m_ifpc_known;
    longint      m_fet, m_bub;

    always @(posedge clk or posedge reset) begin
        longint tgt;
        if (reset) begin
            m_pc = 0; m_instr = NOP; m_ifpc = 0; m_ifpc_known = 1'b1;
            m_valid = 0; m_done = 0; m_mis = 0; m_fet = 0; m_bub = 0;
        end else if (redirect) begin
            tgt = longint'(redirect_pc) - longint'(redirect_pc % 4);
            if (redirect_pc % 4 != 0) m_mis = 1;
            m_instr = NOP; m_valid = 0; m_ifpc = m_pc[31:0]; m_ifpc_known = 1'b1;
            if (tgt + 3 >= IMEM) m_done = 1;
            else begin m_pc = tgt; m_done = 0; end
            m_bub++;
        end else if (m_done) begin
            m_instr = NOP; m_valid = 0; m_ifpc_known = 1'b0;
            m_bub++;
        end else if (stall) begin
            m_bub++;
        end else begin
            m_instr = rom[m_pc / 4]; m_ifpc = m_pc[31:0]; m_ifpc_known = 1'b1; m_valid = 1;
            m_fet++;
            if (m_pc + 4 + 3 >= IMEM) m_done = 1;
            else m_pc = m_pc + 4;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("model_pc", pc, m_pc[31:0]);
            chk("model_imem_addr", imem_addr, m_pc[31:0]);
            chk("model_instr", if_id_instr, m_instr);
            chk("model_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
            chk("model_done", {31'd0, fetch_done}, {31'd0, m_done});
            chk("model_misalign", {31'd0, misalign_err}, {31'd0, m_mis});
            if (m_ifpc_known) chk("model_if_id_pc", if_id_pc, m_ifpc);
`ifdef FETCH_PERF_CNT_EN
            chk("model_perf_fetched", perf_fetched, m_fet[31:0]);
            chk("model_perf_bubbles", perf_bubbles, m_bub[31:0]);
`endif
        end
    end

    task automatic step(input logic st, input logic rd, input logic [31:0] rpc);
        stall = st; redirect = rd; redirect_pc = rpc;
        @(posedge clk);
        #1;
        stall = 1'b0; redirect = 1'b0;
    endtask

    task automatic chk_ifid(input string name, input logic [31:0] epc, input logic [31:0] ei, input logic ev);
        chk({name, "_pc"}, if_id_pc, epc);
        chk({name, "_instr"}, if_id_instr, ei);
        chk({name, "_valid"}, {31'd0, if_id_valid}, {31'd0, ev});
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 32'hC0DE_0000 | 32'(i);
        rom[0]  = 32'hff60_0293;
        rom[1]  = 32'h0052_8333;
        rom[2]  = 32'h4062_83b3;
        rom[11] = 32'h0000_03b3;

        reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        #1 reset = 1'b1;
        #2;
        chk("rst_pc", pc, 32'h0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk_ifid("rst", 32'h0, NOP, 1'b0);
        chk("rst_done", {31'd0, fetch_done}, 32'd0);
        chk("rst_mis", {31'd0, misalign_err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        step(0, 0, 0);
        chk_ifid("seq0", 32'h0, 32'hff60_0293, 1'b1);
        step(0, 0, 0);
        chk_ifid("seq1", 32'h4, 32'h0052_8333, 1'b1);
        chk("seq1_pc", pc, 32'h8);

        step(1, 0, 0);
        step(1, 0, 0);
        chk("stall_pc", pc, 32'h8);
        chk_ifid("stall", 32'h4, 32'h0052_8333, 1'b1);
`ifdef FETCH_PERF_CNT_EN
        chk("stall_perf_fetched", perf_fetched, 32'd2);
        chk("stall_perf_bubbles", perf_bubbles, 32'd2);
`endif
        step(0, 0, 0);
        chk_ifid("seq2", 32'h8, 32'h4062_83b3, 1'b1);
        chk("seq2_pc", pc, 32'hC);

        step(1, 1, 32'h2C);
        chk("redir_pc", pc, 32'h2C);
        chk_ifid("redir", 32'hC, NOP, 1'b0);
        step(0, 0, 0);
        chk_ifid("after_redir", 32'h2C, 32'h0000_03b3, 1'b1);

        for (int i = 0; i < 40 && pc != 32'h7C; i++) step(0, 0, 0);
        chk("reach_7c", pc, 32'h7C);
        step(0, 0, 0);
        chk_ifid("last_word", 32'h7C, 32'hC0DE_001F, 1'b1);
        chk("last_done", {31'd0, fetch_done}, 32'd1);
        chk("last_pc", pc, 32'h7C);
        step(0, 0, 0);
        chk("halt_instr", if_id_instr, NOP);
        chk("halt_valid", {31'd0, if_id_valid}, 32'd0);
        step(1, 0, 0);
        chk("halt_stall_valid", {31'd0, if_id_valid}, 32'd0);
        chk("halt_pc", pc, 32'h7C);
        step(0, 1, 32'h0);
        chk("resume_done", {31'd0, fetch_done}, 32'd0);
        chk("resume_pc", pc, 32'h0);
        step(0, 0, 0);
        chk_ifid("resume", 32'h0, 32'hff60_0293, 1'b1);

        step(0, 1, 32'h80);
        chk("oob_redir_pc", pc, 32'h4);
        chk("oob_redir_done", {31'd0, fetch_done}, 32'd1);
        step(0, 0, 0);
        chk("oob_hold_pc", pc, 32'h4);

        step(0, 1, 32'h6);
        chk("mis_pc", pc, 32'h4);
        chk("mis_err", {31'd0, misalign_err}, 32'd1);
        chk("mis_done", {31'd0, fetch_done}, 32'd0);
        for (int i = 0; i < 10; i++) step(0, 0, 0);
        chk("mis_sticky", {31'd0, misalign_err}, 32'd1);
        chk("mis_run_pc", pc, 32'h2C);

        step(0, 1, 32'h20);
        step(1, 0, 0);
        chk("pre_rst_pc", pc, 32'h20);
        stall = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk("async_rst_pc", pc, 32'h0);
        chk("async_rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("async_rst_instr", if_id_instr, NOP);
        chk("async_rst_mis", {31'd0, misalign_err}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("async_rst_perf_fetched", perf_fetched, 32'd0);
        chk("async_rst_perf_bubbles", perf_bubbles, 32'd0);
`endif
        @(negedge clk);
        stall = 1'b0;
        reset = 1'b0;
        step(0, 0, 0);
        chk_ifid("post_rst", 32'h0, 32'hff60_0293, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
